// File: rtl/axis_ds_pkg.sv
// axis_ds_pkg: shared types, constants and helpers
// for the AXI-Stream width downsizer.
package axis_ds_pkg;

  localparam int DEF_S_W    = 64;
  localparam int DEF_RATIO  = 4;
  localparam int MAX_RATIO  = 16;
  localparam int LANE_IDX_W = 4;

  typedef logic [LANE_IDX_W-1:0] lane_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int lane_count(input int s_w, input int m_w);
    return s_w / m_w;
  endfunction

  function automatic int lane_bytes(input int s_w, input int ratio);
    return s_w / (8 * ratio);
  endfunction

  // Lane that starts every word in the chosen order.
  function automatic lane_t first_lane(input int ratio, input bit msh);
    return msh ? lane_t'(ratio - 1) : '0;
  endfunction

endpackage

// File: rtl/axis_ds_if.sv
// axis_ds_if: one AXI-Stream link (tvalid/tready/tdata/tkeep/tstrb/tlast).
// master drives payload and valid, slave drives ready.
interface axis_ds_if #(
  parameter int DW = 64
) ();

  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;
  logic            tlast;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast,
    output tready
  );

endinterface

// File: rtl/axis_ds_lane_picker.sv
// axis_ds_lane_picker: priority encoder over per-lane nonzero keep.
// in: keep_i, cur_i, msh_i  out: first_o, next_o, last_o.
module axis_ds_lane_picker
  import axis_ds_pkg::*;
#(
  parameter int RATIO = DEF_RATIO,
  parameter int KW    = DEF_S_W / 8,
  parameter int LW    = clog2(RATIO)
) (
  input  logic [KW-1:0] keep_i,
  input  logic [LW-1:0] cur_i,
  input  logic          msh_i,
  output logic [LW-1:0] first_o,
  output logic [LW-1:0] next_o,
  output logic          last_o
);

  localparam int LB = KW / RATIO;

  logic [RATIO-1:0] nz;
  logic [LW-1:0]    fst_m;
  logic [LW-1:0]    fst_l;
  logic [LW-1:0]    nxt_m;
  logic [LW-1:0]    nxt_l;
  logic             has_m;
  logic             has_l;

  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      nz[i] = |keep_i[i*LB +: LB];
    end
  end

  // Empty word falls back to the order's natural first lane.
  always_comb begin
    fst_m = LW'(RATIO - 1);
    fst_l = '0;
    nxt_m = '0;
    nxt_l = '0;
    has_m = 1'b0;
    has_l = 1'b0;
    for (int i = 0; i < RATIO; i++) begin
      if (nz[i]) fst_m = LW'(i);
      if (nz[i] && (LW'(i) < cur_i)) begin
        nxt_m = LW'(i);
        has_m = 1'b1;
      end
    end
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (nz[i]) fst_l = LW'(i);
      if (nz[i] && (LW'(i) > cur_i)) begin
        nxt_l = LW'(i);
        has_l = 1'b1;
      end
    end
  end

  assign first_o = msh_i ? fst_m : fst_l;
  assign next_o  = msh_i ? nxt_m : nxt_l;
  assign last_o  = msh_i ? !has_m : !has_l;

endmodule

// File: rtl/axis_width_downsizer.sv
// axis_width_downsizer: splits one wide AXIS beat into RATIO narrow beats.
// clk axis_aclk, async low reset axis_aresetn, s_axis (wide in), m_axis (narrow out).
module axis_width_downsizer
  import axis_ds_pkg::*;
#(
  parameter int S_TDATA_WIDTH   = DEF_S_W,
  parameter int RATIO           = DEF_RATIO,
  parameter int M_TDATA_WIDTH   = S_TDATA_WIDTH / RATIO,
  parameter bit MSH_FIRST       = 1'b1,
  parameter bit ENABLE_TLAST    = 1'b1,
  parameter bit ENABLE_TKEEP    = 1'b1,
  parameter bit SKIP_NULL_LANES = 1'b0
) (
  input  logic      axis_aclk,
  input  logic      axis_aresetn,
  axis_ds_if.slave  s_axis,
  axis_ds_if.master m_axis
);

  localparam int SKW  = S_TDATA_WIDTH / 8;
  localparam int MKW  = M_TDATA_WIDTH / 8;
  localparam int LW   = clog2(RATIO);
  localparam bit SKIP = SKIP_NULL_LANES && ENABLE_TKEEP;
  localparam logic [LW-1:0] FIRST =
    LW'(first_lane(RATIO, MSH_FIRST));

  logic [S_TDATA_WIDTH-1:0] data_q, data_d;
  logic [SKW-1:0]           keep_q, keep_d;
  logic [SKW-1:0]           strb_q, strb_d;
  logic                     last_q, last_d;
  logic                     hold_v_q, hold_v_d;
  logic [LW-1:0]            cur_lane_q, cur_lane_d;

  logic [SKW-1:0] in_keep;
  logic [SKW-1:0] in_strb;
  logic           in_last;
  logic [SKW-1:0] pk_in;
  logic [SKW-1:0] pk_hold;
  logic           in_any;

  logic [LW-1:0] in_first;
  logic [LW-1:0] in_next;
  logic          in_is_last;
  logic [LW-1:0] hold_first;
  logic [LW-1:0] nxt_lane;
  logic          last_lane;
  logic          unused_pick;

  logic m_hs;
  logic s_rdy;
  logic load;

  assign in_keep = ENABLE_TKEEP ? s_axis.tkeep : '1;
  assign in_strb = ENABLE_TKEEP ? s_axis.tstrb : '1;
  assign in_last = ENABLE_TLAST ? s_axis.tlast : 1'b0;

  // Without skipping every lane looks occupied to the picker.
  assign pk_in   = SKIP ? in_keep : '1;
  assign pk_hold = SKIP ? keep_q  : '1;
  assign in_any  = |pk_in;

  axis_ds_lane_picker #(
    .RATIO (RATIO),
    .KW    (SKW),
    .LW    (LW)
  ) u_pick_in (
    .keep_i  (pk_in),
    .cur_i   (FIRST),
    .msh_i   (MSH_FIRST),
    .first_o (in_first),
    .next_o  (in_next),
    .last_o  (in_is_last)
  );

  axis_ds_lane_picker #(
    .RATIO (RATIO),
    .KW    (SKW),
    .LW    (LW)
  ) u_pick_hold (
    .keep_i  (pk_hold),
    .cur_i   (cur_lane_q),
    .msh_i   (MSH_FIRST),
    .first_o (hold_first),
    .next_o  (nxt_lane),
    .last_o  (last_lane)
  );

  assign unused_pick = ^{in_next, in_is_last, hold_first};

  assign m_hs  = hold_v_q & m_axis.tready;
  assign s_rdy = !hold_v_q | (m_hs & last_lane);
  assign load  = s_axis.tvalid & s_rdy;

  always_comb begin
    data_d     = data_q;
    keep_d     = keep_q;
    strb_d     = strb_q;
    last_d     = last_q;
    hold_v_d   = hold_v_q;
    cur_lane_d = cur_lane_q;
    if (m_hs && !last_lane) cur_lane_d = nxt_lane;
    if (m_hs && last_lane)  hold_v_d   = 1'b0;
    if (load) begin
      data_d     = s_axis.tdata;
      keep_d     = in_keep;
      strb_d     = in_strb;
      last_d     = in_last;
      cur_lane_d = in_first;
      // An all-null word survives only to carry tlast.
      hold_v_d   = in_any | in_last;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      data_q     <= '0;
      keep_q     <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      cur_lane_q <= FIRST;
    end else begin
      data_q     <= data_d;
      keep_q     <= keep_d;
      strb_q     <= strb_d;
      last_q     <= last_d;
      hold_v_q   <= hold_v_d;
      cur_lane_q <= cur_lane_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = hold_v_q;
  assign m_axis.tdata  = hold_v_q ?
    data_q[cur_lane_q*M_TDATA_WIDTH +: M_TDATA_WIDTH] : '0;
  assign m_axis.tkeep  = hold_v_q ?
    keep_q[cur_lane_q*MKW +: MKW] : '0;
  assign m_axis.tstrb  = hold_v_q ?
    strb_q[cur_lane_q*MKW +: MKW] : '0;
  assign m_axis.tlast  = hold_v_q & last_q & last_lane;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb_axis_width_downsizer: directed checks of three downsizer configs
// (MSH first, LSH first, null-lane skipping).
module tb_axis_width_downsizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_ds_if #(.DW(64)) s0 (), s1 (), s2 ();
  axis_ds_if #(.DW(16)) m0 (), m1 (), m2 ();

  logic        tv [3];
  logic [63:0] td [3];
  logic [7:0]  tk [3];
  logic [7:0]  ts [3];
  logic        tl [3];
  logic        mr [3];
  logic        sr [3];
  logic        mv [3];
  logic [15:0] md [3];
  logic [1:0]  mk [3];
  logic [1:0]  ms [3];
  logic        ml [3];

  int checks = 0;
  int errors = 0;

  assign s0.tvalid = tv[0];
  assign s0.tdata  = td[0];
  assign s0.tkeep  = tk[0];
  assign s0.tstrb  = ts[0];
  assign s0.tlast  = tl[0];
  assign m0.tready = mr[0];
  assign sr[0] = s0.tready;
  assign mv[0] = m0.tvalid;
  assign md[0] = m0.tdata;
  assign mk[0] = m0.tkeep;
  assign ms[0] = m0.tstrb;
  assign ml[0] = m0.tlast;

  assign s1.tvalid = tv[1];
  assign s1.tdata  = td[1];
  assign s1.tkeep  = tk[1];
  assign s1.tstrb  = ts[1];
  assign s1.tlast  = tl[1];
  assign m1.tready = mr[1];
  assign sr[1] = s1.tready;
  assign mv[1] = m1.tvalid;
  assign md[1] = m1.tdata;
  assign mk[1] = m1.tkeep;
  assign ms[1] = m1.tstrb;
  assign ml[1] = m1.tlast;

  assign s2.tvalid = tv[2];
  assign s2.tdata  = td[2];
  assign s2.tkeep  = tk[2];
  assign s2.tstrb  = ts[2];
  assign s2.tlast  = tl[2];
  assign m2.tready = mr[2];
  assign sr[2] = s2.tready;
  assign mv[2] = m2.tvalid;
  assign md[2] = m2.tdata;
  assign mk[2] = m2.tkeep;
  assign ms[2] = m2.tstrb;
  assign ml[2] = m2.tlast;

  axis_width_downsizer #(
    .MSH_FIRST (1'b1)
  ) u_dut0 (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis       (s0),
    .m_axis       (m0)
  );

  axis_width_downsizer #(
    .MSH_FIRST (1'b0)
  ) u_dut1 (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis       (s1),
    .m_axis       (m1)
  );

  axis_width_downsizer #(
    .MSH_FIRST       (1'b1),
    .SKIP_NULL_LANES (1'b1)
  ) u_dut2 (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis       (s2),
    .m_axis       (m2)
  );

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Caller must be just after a rising edge.
  task automatic send(input int u, input logic [63:0] d,
                      input logic [7:0] k, input logic [7:0] s,
                      input logic l);
    int n;
    n = 0;
    tv[u] = 1'b1;
    td[u] = d;
    tk[u] = k;
    ts[u] = s;
    tl[u] = l;
    do begin
      @(negedge clk);
      n++;
    end while (!sr[u] && n < 200);
    checks++;
    if (!sr[u]) begin
      errors++;
      $display("FAIL send_accept dut=%0d tready=%b required=1",
               u, sr[u]);
    end
    @(posedge clk);
    #1;
    tv[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({mv[u], sr[u], md[u], mk[u], ml[u]} !==
          {1'b1 ^ 1'b1, 1'b1, 16'h0, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL reset dut=%0d got v=%b rdy=%b d=%h k=%b l=%b required v=0 rdy=1 d=0000 k=00 l=0",
                 u, mv[u], sr[u], md[u], mk[u], ml[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_order(input int u, input logic [63:0] w,
                            input logic [63:0] exp);
    logic [15:0] e;
    logic        lst;
    sync();
    send(u, w, 8'hff, 8'hff, 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      e   = exp[63-16*j -: 16];
      lst = (j == 3);
      checks++;
      if ({mv[u], md[u], mk[u], ml[u], sr[u]} !==
          {1'b1, e, 2'b11, lst, lst}) begin
        errors++;
        $display("FAIL order dut=%0d beat=%0d got v=%b d=%h k=%b l=%b rdy=%b required v=1 d=%h k=11 l=%b rdy=%b",
                 u, j, mv[u], md[u], mk[u], ml[u], sr[u], e, lst, lst);
      end
    end
    @(negedge clk);
    checks++;
    if ({mv[u], md[u]} !== 17'h0) begin
      errors++;
      $display("FAIL order_idle dut=%0d got v=%b d=%h required v=0 d=0000",
               u, mv[u], md[u]);
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [15:0] e;
    sync();
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          logic [7:0] b;
          b = 8'(w);
          send(0, {b, 8'd3, b, 8'd2, b, 8'd1, b, 8'd0},
               8'hff, 8'hff, 1'b0);
        end
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!mv[0] && n < 20);
        for (int j = 0; j < 32; j++) begin
          if (j > 0) @(negedge clk);
          e = {8'(j / 4), 8'(3 - j % 4)};
          checks++;
          if ({mv[0], md[0], ml[0], sr[0]} !==
              {1'b1, e, 1'b0, (j % 4 == 3)}) begin
            errors++;
            $display("FAIL b2b beat=%0d got v=%b d=%h l=%b rdy=%b required v=1 d=%h l=0 rdy=%b",
                     j, mv[0], md[0], ml[0], sr[0], e, (j % 4 == 3));
          end
        end
      end
    join
  endtask

  task automatic test_backpressure();
    int          idx;
    int          cyc;
    logic        stalled;
    logic [15:0] prev;
    logic [15:0] e;
    sync();
    fork
      begin
        for (int w = 0; w < 6; w++) begin
          logic [7:0] b;
          b = 8'(w + 16);
          send(0, {b, 8'd3, b, 8'd2, b, 8'd1, b, 8'd0},
               8'hff, 8'hff, (w == 5));
        end
      end
      begin
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        prev    = '0;
        while (idx < 24 && cyc < 600) begin
          @(posedge clk);
          #1;
          mr[0] = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
          if (stalled) begin
            checks++;
            if ({mv[0], md[0]} !== {1'b1, prev}) begin
              errors++;
              $display("FAIL stall_hold got v=%b d=%h required v=1 d=%h",
                       mv[0], md[0], prev);
            end
          end
          if (mv[0] && mr[0]) begin
            e = {8'(idx / 4 + 16), 8'(3 - idx % 4)};
            checks++;
            if ({md[0], ml[0]} !== {e, (idx == 23)}) begin
              errors++;
              $display("FAIL bp_beat idx=%0d got d=%h l=%b required d=%h l=%b",
                       idx, md[0], ml[0], e, (idx == 23));
            end
            idx++;
          end
          stalled = mv[0] && !mr[0];
          prev    = md[0];
        end
        mr[0] = 1'b1;
        checks++;
        if (idx != 24) begin
          errors++;
          $display("FAIL bp_count got %0d beats required 24", idx);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra got v=%b required v=0", mv[0]);
    end
  endtask

  task automatic test_null_skip();
    sync();
    send(2, 64'hAAAA_BBBB_CCCC_DDDD, 8'b1100_1100, 8'b1000_1100, 1'b1);
    @(negedge clk);
    checks++;
    if ({mv[2], md[2], mk[2], ms[2], ml[2], sr[2]} !==
        {1'b1, 16'hAAAA, 2'b11, 2'b10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL skip_b0 got v=%b d=%h k=%b s=%b l=%b rdy=%b required v=1 d=aaaa k=11 s=10 l=0 rdy=0",
               mv[2], md[2], mk[2], ms[2], ml[2], sr[2]);
    end
    @(negedge clk);
    checks++;
    if ({mv[2], md[2], mk[2], ms[2], ml[2], sr[2]} !==
        {1'b1, 16'hCCCC, 2'b11, 2'b11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL skip_b1 got v=%b d=%h k=%b s=%b l=%b rdy=%b required v=1 d=cccc k=11 s=11 l=1 rdy=1",
               mv[2], md[2], mk[2], ms[2], ml[2], sr[2]);
    end
    @(negedge clk);
    checks++;
    if (mv[2] !== 1'b0) begin
      errors++;
      $display("FAIL skip_end got v=%b required v=0", mv[2]);
    end
    sync();
    send(2, 64'h1234_5678_9ABC_DEF0, 8'h00, 8'h00, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({mv[2], sr[2]} !== 2'b01) begin
        errors++;
        $display("FAIL null_drop cyc=%0d got v=%b rdy=%b required v=0 rdy=1",
                 j, mv[2], sr[2]);
      end
    end
    sync();
    send(2, 64'hFEDC_BA98_7654_3210, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    checks++;
    if ({mv[2], md[2], mk[2], ms[2], ml[2], sr[2]} !==
        {1'b1, 16'hFEDC, 2'b00, 2'b00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL null_last got v=%b d=%h k=%b s=%b l=%b rdy=%b required v=1 d=fedc k=00 s=00 l=1 rdy=1",
               mv[2], md[2], mk[2], ms[2], ml[2], sr[2]);
    end
    @(negedge clk);
    checks++;
    if (mv[2] !== 1'b0) begin
      errors++;
      $display("FAIL null_last_end got v=%b required v=0", mv[2]);
    end
  endtask

  task automatic test_reset_midword();
    logic [63:0] exp;
    logic [15:0] e;
    sync();
    send(0, 64'h5555_6666_7777_8888, 8'hff, 8'hff, 1'b1);
    @(negedge clk);
    checks++;
    if ({mv[0], md[0]} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL rst_pre0 got v=%b d=%h required v=1 d=5555",
               mv[0], md[0]);
    end
    @(negedge clk);
    checks++;
    if ({mv[0], md[0]} !== {1'b1, 16'h6666}) begin
      errors++;
      $display("FAIL rst_pre1 got v=%b d=%h required v=1 d=6666",
               mv[0], md[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mv[0], md[0], ml[0], sr[0]} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async got v=%b d=%h l=%b rdy=%b required v=0 d=0000 l=0 rdy=1",
               mv[0], md[0], ml[0], sr[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got v=%b required v=0", mv[0]);
    end
    exp = 64'h9999_AAAA_BBBB_CCCC;
    sync();
    send(0, exp, 8'hff, 8'hff, 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      e = exp[63-16*j -: 16];
      checks++;
      if ({mv[0], md[0], ml[0]} !== {1'b1, e, (j == 3)}) begin
        errors++;
        $display("FAIL rst_next beat=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                 j, mv[0], md[0], ml[0], e, (j == 3));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      tv[u] = 1'b0;
      td[u] = '0;
      tk[u] = '0;
      ts[u] = '0;
      tl[u] = 1'b0;
      mr[u] = 1'b1;
    end
    test_reset();
    test_order(0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
    test_order(1, 64'h1111_2222_3333_4444, 64'h4444_3333_2222_1111);
    test_back_to_back();
    test_backpressure();
    test_null_skip();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
